// File: rtl/register_file_pkg.sv
// Shared widths, constants and the per-register entry layout for the register file.
package register_file_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned ROB_ID_W = 5;
  localparam int unsigned REG_NUM  = 32;
  localparam int unsigned REG_ID_W = 5;

  localparam logic [ROB_ID_W-1:0] NO_TAG = '0;

  typedef struct packed {
    logic                busy;
    logic [ROB_ID_W-1:0] tag;
    logic [XLEN-1:0]     value;
  } reg_entry_t;

endpackage

// File: rtl/register_file_read_port.sv
// One decoder operand port: applies the x0 rule, the busy masking and the commit bypass.
module register_file_read_port
  import register_file_pkg::*;
(
  input  logic [REG_ID_W-1:0] reg_id,
  input  reg_entry_t          entry,
  input  logic                commit_ready,
  input  logic [REG_ID_W-1:0] commit_register_id,
  input  logic [ROB_ID_W-1:0] commit_rob_id,
  input  logic [XLEN-1:0]     commit_value,
  output logic                busy,
  output logic [ROB_ID_W-1:0] rob_id,
  output logic [XLEN-1:0]     value
);

  logic bypass_hit;

  // A retiring commit that still owns the register's tag resolves the operand this cycle.
  always_comb begin
    busy       = 1'b0;
    rob_id     = NO_TAG;
    value      = '0;
    bypass_hit = commit_ready && (commit_register_id == reg_id) &&
                 entry.busy && (entry.tag == commit_rob_id);
    if (reg_id != '0) begin
      if (bypass_hit) begin
        value = commit_value;
      end else if (entry.busy) begin
        busy   = 1'b1;
        rob_id = entry.tag;
      end else begin
        value = entry.value;
      end
    end
  end

endmodule

// File: rtl/register_file.sv
// Architectural register file with rename tags, fed by the ROB launch and commit streams.
module register_file
  import register_file_pkg::*;
(
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                _clear,
  input  logic                _rf_launch_ready,
  input  logic [ROB_ID_W-1:0] _rf_launch_rob_id,
  input  logic [REG_ID_W-1:0] _rf_launch_register_id,
  input  logic                _rf_commit_ready,
  input  logic [ROB_ID_W-1:0] _rf_commit_rob_id,
  input  logic [REG_ID_W-1:0] _rf_commit_register_id,
  input  logic [XLEN-1:0]     _rf_commit_value,
  input  logic [REG_ID_W-1:0] _get_register_id_1,
  input  logic [REG_ID_W-1:0] _get_register_id_2,
  output logic                _reg_busy_1,
  output logic                _reg_busy_2,
  output logic [ROB_ID_W-1:0] _reg_rob_id_1,
  output logic [ROB_ID_W-1:0] _reg_rob_id_2,
  output logic [XLEN-1:0]     _reg_value_1,
  output logic [XLEN-1:0]     _reg_value_2
);

  // x0 has no storage; entries exist only for x1..x31.
  reg_entry_t regs [1:REG_NUM-1];
  reg_entry_t entry_1;
  reg_entry_t entry_2;

  // Pick the stored entry for each operand; x0 selects an all-zero entry.
  always_comb begin
    entry_1 = '0;
    entry_2 = '0;
    for (int i = 1; i < REG_NUM; i++) begin
      if (_get_register_id_1 == REG_ID_W'(i)) entry_1 = regs[i];
      if (_get_register_id_2 == REG_ID_W'(i)) entry_2 = regs[i];
    end
  end

  // Commit writes value and releases a matching tag; clear drops all tags; launch renames last.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 1; i < REG_NUM; i++) begin
        regs[i] <= '0;
      end
    end else if (rdy_in) begin
      for (int i = 1; i < REG_NUM; i++) begin
        if (_rf_commit_ready && (_rf_commit_register_id == REG_ID_W'(i))) begin
          regs[i].value <= _rf_commit_value;
          if (regs[i].busy && (regs[i].tag == _rf_commit_rob_id)) begin
            regs[i].busy <= 1'b0;
            regs[i].tag  <= NO_TAG;
          end
        end
        if (_clear) begin
          regs[i].busy <= 1'b0;
          regs[i].tag  <= NO_TAG;
        end else if (_rf_launch_ready && (_rf_launch_register_id == REG_ID_W'(i))) begin
          regs[i].busy <= 1'b1;
          regs[i].tag  <= _rf_launch_rob_id;
        end
      end
    end
  end

  register_file_read_port u_read_port_1 (
    .reg_id             (_get_register_id_1),
    .entry              (entry_1),
    .commit_ready       (_rf_commit_ready),
    .commit_register_id (_rf_commit_register_id),
    .commit_rob_id      (_rf_commit_rob_id),
    .commit_value       (_rf_commit_value),
    .busy               (_reg_busy_1),
    .rob_id             (_reg_rob_id_1),
    .value              (_reg_value_1)
  );

  register_file_read_port u_read_port_2 (
    .reg_id             (_get_register_id_2),
    .entry              (entry_2),
    .commit_ready       (_rf_commit_ready),
    .commit_register_id (_rf_commit_register_id),
    .commit_rob_id      (_rf_commit_rob_id),
    .commit_value       (_rf_commit_value),
    .busy               (_reg_busy_2),
    .rob_id             (_reg_rob_id_2),
    .value              (_reg_value_2)
  );

endmodule

// File: tb/tb_register_file.sv
// Directed table-driven bench for register_file; each row is one cycle, checked before its edge.
module tb_register_file;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clr;
  logic        l_rdy;
  logic [4:0]  l_id;
  logic [4:0]  l_reg;
  logic        c_rdy;
  logic [4:0]  c_id;
  logic [4:0]  c_reg;
  logic [31:0] c_val;
  logic [4:0]  g1;
  logic [4:0]  g2;
  logic        b1;
  logic        b2;
  logic [4:0]  t1;
  logic [4:0]  t2;
  logic [31:0] v1;
  logic [31:0] v2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          rdy;
    bit          clr;
    bit          lv;
    int          lreg;
    int          lid;
    bit          cv;
    int          creg;
    int          cid;
    logic [31:0] cval;
    int          g1;
    int          g2;
    bit          eb1;
    int          et1;
    logic [31:0] ev1;
    bit          eb2;
    int          et2;
    logic [31:0] ev2;
  } vec_t;

  vec_t vq[$];

  always #5 clk_in = ~clk_in;

  register_file dut (
    .clk_in                 (clk_in),
    .rst_in                 (rst_in),
    .rdy_in                 (rdy_in),
    ._clear                 (clr),
    ._rf_launch_ready       (l_rdy),
    ._rf_launch_rob_id      (l_id),
    ._rf_launch_register_id (l_reg),
    ._rf_commit_ready       (c_rdy),
    ._rf_commit_rob_id      (c_id),
    ._rf_commit_register_id (c_reg),
    ._rf_commit_value       (c_val),
    ._get_register_id_1     (g1),
    ._get_register_id_2     (g2),
    ._reg_busy_1            (b1),
    ._reg_busy_2            (b2),
    ._reg_rob_id_1          (t1),
    ._reg_rob_id_2          (t2),
    ._reg_value_1           (v1),
    ._reg_value_2           (v2)
  );

  function automatic void add(bit rdy, bit c, bit lv, int lreg, int lid,
                              bit cv, int creg, int cid, logic [31:0] cval,
                              int ga, int gb,
                              bit eb1, int et1, logic [31:0] ev1,
                              bit eb2, int et2, logic [31:0] ev2);
    vec_t v;
    v.rdy = rdy; v.clr = c; v.lv = lv; v.lreg = lreg; v.lid = lid;
    v.cv = cv; v.creg = creg; v.cid = cid; v.cval = cval;
    v.g1 = ga; v.g2 = gb;
    v.eb1 = eb1; v.et1 = et1; v.ev1 = ev1;
    v.eb2 = eb2; v.et2 = et2; v.ev2 = ev2;
    vq.push_back(v);
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic drive_idle();
    rdy_in = 1'b1; clr = 1'b0;
    l_rdy = 1'b0; l_id = '0; l_reg = '0;
    c_rdy = 1'b0; c_id = '0; c_reg = '0; c_val = '0;
  endtask

  task automatic check_ports(input int idx, input bit eb1, input int et1, input logic [31:0] ev1,
                             input bit eb2, input int et2, input logic [31:0] ev2);
    check("busy_1",   idx, 32'(b1), 32'(eb1));
    check("rob_id_1", idx, 32'(t1), 32'(et1));
    check("value_1",  idx, v1, ev1);
    check("busy_2",   idx, 32'(b2), 32'(eb2));
    check("rob_id_2", idx, 32'(t2), 32'(et2));
    check("value_2",  idx, v2, ev2);
  endtask

  initial begin
    //   rdy clr lv lreg lid  cv creg cid cval          g1 g2  eb1 et1 ev1           eb2 et2 ev2
    add(1, 0, 0, 0, 0,   0, 0, 0, 32'h0,         5, 0,  0, 0, 32'h0,         0, 0, 32'h0);
    add(1, 0, 1, 5, 3,   0, 0, 0, 32'h0,         5, 0,  0, 0, 32'h0,         0, 0, 32'h0);
    add(1, 0, 0, 0, 0,   0, 0, 0, 32'h0,         5, 0,  1, 3, 32'h0,         0, 0, 32'h0);
    add(1, 0, 0, 0, 0,   1, 5, 3, 32'hDEADBEEF,  5, 5,  0, 0, 32'hDEADBEEF,  0, 0, 32'hDEADBEEF);
    add(1, 0, 0, 0, 0,   0, 0, 0, 32'h0,         5, 0,  0, 0, 32'hDEADBEEF,  0, 0, 32'h0);
    add(1, 0, 1, 7, 2,   0, 0, 0, 32'h0,         7, 5,  0, 0, 32'h0,         0, 0, 32'hDEADBEEF);
    add(1, 0, 1, 7, 4,   0, 0, 0, 32'h0,         7, 0,  1, 2, 32'h0,         0, 0, 32'h0);
    add(1, 0, 0, 0, 0,   1, 7, 2, 32'h11,        7, 7,  1, 4, 32'h0,         1, 4, 32'h0);
    add(1, 0, 0, 0, 0,   0, 0, 0, 32'h0,         7, 0,  1, 4, 32'h0,         0, 0, 32'h0);
    add(1, 0, 1, 9, 5,   0, 0, 0, 32'h0,         9, 0,  0, 0, 32'h0,         0, 0, 32'h0);
    add(1, 0, 0, 0, 0,   0, 0, 0, 32'h0,         9, 0,  1, 5, 32'h0,         0, 0, 32'h0);
    add(1, 0, 1, 9, 6,   1, 9, 5, 32'h22,        9, 9,  0, 0, 32'h22,        0, 0, 32'h22);
    add(1, 0, 0, 0, 0,   0, 0, 0, 32'h0,         9, 0,  1, 6, 32'h0,         0, 0, 32'h0);
    add(1, 0, 1, 1, 10,  0, 0, 0, 32'h0,         1, 2,  0, 0, 32'h0,         0, 0, 32'h0);
    add(1, 0, 1, 2, 11,  0, 0, 0, 32'h0,         1, 0,  1, 10, 32'h0,        0, 0, 32'h0);
    add(1, 0, 1, 3, 12,  0, 0, 0, 32'h0,         2, 1,  1, 11, 32'h0,        1, 10, 32'h0);
    add(1, 1, 1, 4, 8,   1, 1, 10, 32'h33,       1, 3,  0, 0, 32'h33,        1, 12, 32'h0);
    add(1, 0, 0, 0, 0,   0, 0, 0, 32'h0,         1, 4,  0, 0, 32'h33,        0, 0, 32'h0);
    add(1, 0, 0, 0, 0,   0, 0, 0, 32'h0,         7, 9,  0, 0, 32'h11,        0, 0, 32'h22);
    add(1, 0, 0, 0, 0,   0, 0, 0, 32'h0,         2, 3,  0, 0, 32'h0,         0, 0, 32'h0);
    add(0, 0, 1, 10, 1,  0, 0, 0, 32'h0,         10, 0, 0, 0, 32'h0,         0, 0, 32'h0);
    add(1, 0, 0, 0, 0,   0, 0, 0, 32'h0,         10, 5, 0, 0, 32'h0,         0, 0, 32'hDEADBEEF);
    add(1, 0, 1, 11, 7,  0, 0, 0, 32'h0,         11, 0, 0, 0, 32'h0,         0, 0, 32'h0);
    add(0, 1, 0, 0, 0,   0, 0, 0, 32'h0,         11, 0, 1, 7, 32'h0,         0, 0, 32'h0);
    add(1, 0, 0, 0, 0,   0, 0, 0, 32'h0,         11, 0, 1, 7, 32'h0,         0, 0, 32'h0);
    add(0, 0, 0, 0, 0,   1, 11, 7, 32'h77,       11, 0, 0, 0, 32'h77,        0, 0, 32'h0);
    add(1, 0, 0, 0, 0,   0, 0, 0, 32'h0,         11, 0, 1, 7, 32'h0,         0, 0, 32'h0);
    add(1, 0, 0, 0, 0,   1, 11, 7, 32'h77,       11, 0, 0, 0, 32'h77,        0, 0, 32'h0);
    add(1, 0, 0, 0, 0,   0, 0, 0, 32'h0,         11, 0, 0, 0, 32'h77,        0, 0, 32'h0);
    add(1, 0, 1, 0, 9,   1, 0, 9, 32'h99,        0, 0,  0, 0, 32'h0,         0, 0, 32'h0);
    add(1, 0, 0, 0, 0,   0, 0, 0, 32'h0,         0, 0,  0, 0, 32'h0,         0, 0, 32'h0);

    rst_in = 1'b0;
    drive_idle();
    g1 = 5'd0; g2 = 5'd0;
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b1;

    foreach (vq[i]) begin
      rdy_in = vq[i].rdy;
      clr    = vq[i].clr;
      l_rdy  = vq[i].lv;
      l_reg  = 5'(vq[i].lreg);
      l_id   = 5'(vq[i].lid);
      c_rdy  = vq[i].cv;
      c_reg  = 5'(vq[i].creg);
      c_id   = 5'(vq[i].cid);
      c_val  = vq[i].cval;
      g1     = 5'(vq[i].g1);
      g2     = 5'(vq[i].g2);
      #3;
      check_ports(i, vq[i].eb1, vq[i].et1, vq[i].ev1, vq[i].eb2, vq[i].et2, vq[i].ev2);
      @(posedge clk_in);
      #1;
    end

    // Asynchronous reset mid-cycle drops a live tag and stored values at once.
    drive_idle();
    l_rdy = 1'b1; l_reg = 5'd12; l_id = 5'd13;
    @(posedge clk_in);
    #1 drive_idle();
    g1 = 5'd12; g2 = 5'd5;
    #2 check_ports(100, 1'b1, 13, 32'h0, 1'b0, 0, 32'hDEADBEEF);
    rst_in = 1'b0;
    #1 check_ports(101, 1'b0, 0, 32'h0, 1'b0, 0, 32'h0);
    @(posedge clk_in);
    #1 rst_in = 1'b1;
    g1 = 5'd7; g2 = 5'd11;
    #2 check_ports(102, 1'b0, 0, 32'h0, 1'b0, 0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file.md
# register_file

Architectural register file with per-register rename tags; it sits directly downstream of the reorder buffer. It consumes the ROB's launch stream, which marks a destination register as pending on a ROB entry. It also consumes the commit stream, which writes the retired value and releases the tag when it still matches. The decoder reads two operands per cycle and receives either a committed value or the ROB id to wait on.

## Interface
Parameters
- XLEN, 32, data width
- ROB_ID_W, 5, ROB entry id width; valid ids are 1..31, and 0 means "no tag"

Ports
- clk_in  input  1  system clock; all state updates on rising edge
- rst_in  input  1  asynchronous, active-low reset
- rdy_in  input  1  ready; when low, no state changes (outputs stay combinational)
- _clear  input  1  mispredict flush from ROB
- _rf_launch_ready  input  1  allocate a tag this cycle
- _rf_launch_rob_id  input  ROB_ID_W  tag to allocate (never 0)
- _rf_launch_register_id  input  5  destination register
- _rf_commit_ready  input  1  retire a value this cycle
- _rf_commit_rob_id  input  ROB_ID_W  tag of the retiring entry
- _rf_commit_register_id  input  5  destination register
- _rf_commit_value  input  XLEN  retired value
- _get_register_id_1 / _get_register_id_2  input  5  operand register ids from the decoder
- _reg_busy_1 / _reg_busy_2  output  1  operand is waiting on a ROB entry
- _reg_rob_id_1 / _reg_rob_id_2  output  ROB_ID_W  pending tag; 0 when not busy
- _reg_value_1 / _reg_value_2  output  XLEN  committed value; 0 when busy

## Operation
- State per register x1..x31: value[XLEN], busy, tag[ROB_ID_W]. x0 has no storage; it always reads busy=0, tag=0, value=0 and ignores all writes.
- Commit (rdy_in high, commit_ready, reg≠0):
  - value[r] ← commit_value unconditionally.
  - busy/tag cleared only if busy[r] and tag[r]==commit_rob_id. A younger launch has already renamed r otherwise.
- Launch (rdy_in high, launch_ready, reg≠0, _clear low): busy[r] ← 1, tag[r] ← launch_rob_id.
- Commit and launch to the same register in the same cycle: the value is written, and the launch tag wins, so busy=1 and tag=launch id.
- _clear (with rdy_in high):
  - All busy bits and tags are zeroed.
  - Launch in the same cycle is dropped.
  - Commit in the same cycle still writes its value, because the ROB head is non-speculative.
- Read ports are combinational and see pre-edge state, with commit bypass:
  - If commit_ready, commit reg == get id ≠ 0, and the stored tag matches: output busy=0, tag=0, value=commit_value.
  - Same-cycle launch is NOT visible to reads, so rd==rs returns the old mapping.
- Reset: all values 0, busy 0, tags 0. Outputs after reset are busy=0, rob_id=0, value=0 for every id.

## Timing
- Read latency 0 cycles (combinational). Write latency 1 edge.
- A launch at edge N is visible to reads from cycle N+1.
- Commit bypass makes a retiring value visible in the same cycle it is presented.
- rdy_in low freezes all state, including _clear effects. Read outputs still reflect stored state plus bypass.
- Asynchronous reset mid-operation drops every pending tag immediately. No handshake is outstanding, since the block has no backpressure.
- Tag reuse: ROB ids wrap 31→1. A stale commit whose id equals a newer live tag cannot occur, because the ROB holds at most 31 entries. The block does not check for it.

## Structure
- Shared package: XLEN, ROB_ID_W, REG_NUM=32, and the constant NO_TAG=0.
- One sub-module, register_file_read_port, instantiated twice. It takes the stored entry plus the commit bus and produces busy/tag/value with the bypass and x0 rule.
- The main module holds the state arrays and the write/clear logic.

## Test plan
- Reset, then read x5 and x0 → busy=0, rob_id=0, value=0 on both ports.
- Launch x5 tag 3; next cycle read x5 → busy=1, rob_id=3, value=0. Then commit x5 tag 3 value 0xDEADBEEF → same-cycle read gives busy=0, value=0xDEADBEEF, and the state persists afterwards.
- Launch x7 tag 2, then launch x7 tag 4, then commit x7 tag 2 value 0x11 → x7 stays busy=1, tag=4, and the stored value is 0x11 (reads show value 0 while busy).
- Same cycle: launch x9 tag 6 and commit x9 (matching old tag 5) value 0x22 → next cycle busy=1, tag=6. A same-cycle read with rs==x9 shows busy=0, value=0x22.
- Launch x1..x3, then _clear together with commit x1 value 0x33 and launch x4 tag 8 → all busy=0, x1 value=0x33, x4 not busy.
- Hold rdy_in low with launch x10 tag 1 → no change. Launch/commit on x0 → x0 still reads 0 and not busy.
